crc32_stream: RTL
=================

# crc32_stream

Parametrised CRC-32 engine for PNG chunk generation: consumes a byte-packed stream of up to DATA_WD/8 bytes per beat, MSB byte first, and returns the finished PNG/zlib CRC-32 together with the byte count of the covered region. It sits between the chunk assembler and the output packer, replacing the fixed 32-bit CRC block. It adds configurable lane width, valid/ready backpressure on both sides, a held result, and start-abort.

## Interface
- DATA_WD, 32: input beat width in bits; multiple of 8, range 8..128.
- NUM_WD, 2: width of num_i; equals max(1, clog2(DATA_WD/8)).
- LEN_WD, 32: width of the byte counter len_o.
- clk  in  1  clock; all state updates on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle pulse that clears the CRC and counter and arms the engine; accepted in any state.
- val_i  in  1  input beat valid.
- rdy_o  out  1  input ready; high only in RUN.
- dat_i  in  DATA_WD  input bytes; byte 0 = dat_i[DATA_WD-1 -: 8].
- num_i  in  NUM_WD  valid byte count minus 1, MSB-aligned; values ≥ DATA_WD/8 are clipped to DATA_WD/8 bytes.
- lst_i  in  1  marks the final beat of the region.
- val_o  out  1  result valid; held until accepted.
- rdy_i  in  1  result ready from the consumer.
- dat_o  out  32  final CRC-32, already complemented.
- len_o  out  LEN_WD  number of bytes covered.
- done_o  out  1  one-cycle pulse in the cycle the result is accepted.

## Operation
- Algorithm: reflected polynomial 0xEDB88320, seed 0xFFFFFFFF, final XOR 0xFFFFFFFF. Each byte is processed LSB-first.
- Bytes within a beat are folded in the order 0, 1, …, num_i. The fold is an unrolled combinational chain of DATA_WD/8 byte stages. Masked lanes pass the CRC through unchanged.
- FSM states:
  - IDLE (reset state).
  - RUN.
  - OUT.
- Transitions:
  - start_i → RUN from any state. crc_r becomes 0xFFFFFFFF, cnt_r becomes 0, and any pending result is discarded (val_o drops the next cycle).
  - In RUN, val_i && rdy_o accepts a beat:
    - crc_r takes the fold result.
    - cnt_r increments by num_i+1 (after clipping).
    - cnt_r saturates at 2^LEN_WD-1.
  - An accepted beat with lst_i moves RUN → OUT. The registered dat_o = ~crc_next and len_o = cnt_next.
  - In OUT, val_o=1; rdy_i high gives a done_o pulse and a move to IDLE.
  - Priority rule: start_i wins over val_i and over rdy_i in the same cycle. The beat is not accepted and no done_o is pulsed.
- val_i in IDLE or OUT is ignored. No state changes.
- dat_o and len_o hold their last values outside OUT until the next result is registered.

## Timing
- Reset values:
  - rdy_o=0, val_o=0, done_o=0.
  - dat_o=0, len_o=0.
  - State IDLE, crc_r=0xFFFFFFFF, cnt_r=0.
- rdy_o is high from the cycle after start_i until the cycle after the lst beat is accepted.
- Throughput: one beat per cycle in RUN.
- Latency: last beat accepted at edge N → val_o and dat_o valid after edge N. A zero-wait consumer accepts at edge N+1, which also gives done_o=1 after N+1 (one cycle).
- Back-to-back: a start_i in the cycle after acceptance opens a new region with no bubble.
- Reset mid-operation: asynchronous return to the reset values. No result is emitted.
- val_o stays high and dat_o/len_o stay stable for as long as rdy_i=0.

## Test plan
- DATA_WD=32: start; one beat 0x49454E44 ("IEND"), num_i=3, lst_i=1 → dat_o=0xAE426082, len_o=4, done_o pulse on rdy_i.
- DATA_WD=32: "123456789" as beats of num_i=3, 3, 0 (the last beat byte '9' at dat_i[31:24], lst_i on it) → dat_o=0xCBF43926, len_o=9.
- DATA_WD=8 and DATA_WD=128 builds: the same "123456789" stream → 0xCBF43926 in both; the 128-bit build accepts it in one beat with num_i=8.
- Backpressure: rdy_i=0 for 20 cycles after val_o rises → val_o, dat_o and len_o stable; done_o is asserted only in the accept cycle; val_i pulses during OUT are ignored.
- Abort: start_i asserted mid-region together with val_i, then "IEND" → the old partial data has no effect and dat_o=0xAE426082; start_i in OUT clears val_o with no done_o.
- Reset: rstn pulled low while val_o=1 → all outputs return to 0 immediately (asynchronously) and rdy_o stays 0 until the next start_i.

Source files
------------

// File: rtl/crc32_stream_if.sv
// Handshake bundle for crc32_stream: byte-packed input beats and the held CRC result.
// Signal names are written from the engine's point of view (_i into the engine, _o out of it).
interface crc32_stream_if #(
    parameter int DATA_WD = 32,
    parameter int NUM_WD  = 2,
    parameter int LEN_WD  = 32
);
    logic               start_i;
    logic               val_i;
    logic               rdy_o;
    logic [DATA_WD-1:0] dat_i;
    logic [NUM_WD-1:0]  num_i;
    logic               lst_i;
    logic               val_o;
    logic               rdy_i;
    logic [31:0]        dat_o;
    logic [LEN_WD-1:0]  len_o;
    logic               done_o;

    modport master (
        output start_i, val_i, dat_i, num_i, lst_i, rdy_i,
        input  rdy_o, val_o, dat_o, len_o, done_o
    );

    modport slave (
        input  start_i, val_i, dat_i, num_i, lst_i, rdy_i,
        output rdy_o, val_o, dat_o, len_o, done_o
    );
endinterface

// File: rtl/crc32_stream.sv
// Streaming PNG/zlib CRC-32 (reflected 0xEDB88320) over MSB-first byte lanes,
// with a saturating byte count and a result held until the consumer takes it.
module crc32_stream #(
    parameter int DATA_WD = 32,
    parameter int NUM_WD  = 2,
    parameter int LEN_WD  = 32
) (
    input  logic           clk,
    input  logic           rstn,
    crc32_stream_if.slave  bus
);
    localparam int               NB   = DATA_WD / 8;
    localparam logic [31:0]      POLY = 32'hEDB88320;
    localparam logic [NUM_WD:0]  NB_W = (NUM_WD + 1)'(NB);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]        r_state;
    logic [31:0]       r_crc;
    logic [LEN_WD-1:0] r_cnt;
    logic [31:0]       r_dat;
    logic [LEN_WD-1:0] r_len;
    logic              r_done;

    logic [NUM_WD:0]       w_nb;
    logic [NB:0][31:0]     w_chain;
    logic [31:0]           w_crc_nxt;
    logic [LEN_WD:0]       w_cnt_sum;
    logic [LEN_WD-1:0]     w_cnt_nxt;

    function automatic logic [31:0] f_crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++)
            x = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
        return x;
    endfunction

    // Byte count of this beat; oversize num_i is clipped to a full beat.
    assign w_nb = ({1'b0, bus.num_i} >= NB_W) ? NB_W : ({1'b0, bus.num_i} + (NUM_WD + 1)'(1));

    assign w_chain[0] = r_crc;
    generate
        for (genvar k = 0; k < NB; k++) begin : g_lane
            localparam logic [NUM_WD:0] LANE = (NUM_WD + 1)'(k);
            assign w_chain[k+1] = (LANE < w_nb) ?
                f_crc_byte(w_chain[k], bus.dat_i[DATA_WD-1-8*k -: 8]) : w_chain[k];
        end
    endgenerate
    assign w_crc_nxt = w_chain[NB];

    assign w_cnt_sum = {1'b0, r_cnt} + (LEN_WD + 1)'(w_nb);
    assign w_cnt_nxt = w_cnt_sum[LEN_WD] ? '1 : w_cnt_sum[LEN_WD-1:0];

    // start_i preempts any beat or result handshake in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_crc   <= 32'hFFFFFFFF;
            r_cnt   <= '0;
            r_dat   <= '0;
            r_len   <= '0;
            r_done  <= 1'b0;
        end else if (bus.start_i) begin
            r_state <= S_RUN;
            r_crc   <= 32'hFFFFFFFF;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (bus.val_i) begin
                        r_crc <= w_crc_nxt;
                        r_cnt <= w_cnt_nxt;
                        if (bus.lst_i) begin
                            r_state <= S_OUT;
                            r_dat   <= ~w_crc_nxt;
                            r_len   <= w_cnt_nxt;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.rdy_i) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rdy_o  = (r_state == S_RUN);
    assign bus.val_o  = (r_state == S_OUT);
    assign bus.dat_o  = r_dat;
    assign bus.len_o  = r_len;
    assign bus.done_o = r_done;
endmodule
